sdram_cmd_sequencer: RTL and testbench

//  Host-side initiator for the sdram_controls command interface. Accepts one read/write request per handshake and issues
//  the PRECHARGE -> ACTIVATE -> READ/WRITE command sequence on active-low CS/RAS/CAS/WeOut.

---
 rtl/sdram_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sdram_cmd_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_sequencer.sv
// Host-side PRECHARGE -> ACTIVATE -> READ/WRITE sequencer for the sdram_controls command port.
// Optional macro OPEN_ROW_EN: remember the last activated row and skip PRE/ACT on a row hit.
module sdram_cmd_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic             ReqWe,
   input  logic [31:0]      ReqAddr,
   input  logic [1:0]       ReqSize,
   input  logic [CNT_W-1:0] tpre,
   input  logic [CNT_W-1:0] tcas,
   input  logic [3:0]       tlat,
   input  logic [CNT_W-1:0] tburst,
   input  logic [CNT_W-1:0] twait,
   output logic             CS,
   output logic             RAS,
   output logic             CAS,
   output logic             WeOut,
   output logic [31:0]      AddrOut,
   output logic [1:0]       SizeOut,
   output logic             Busy,
   output logic             Done
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_PRE_W, S_ACT, S_ACT_W, S_RW, S_DATA, S_REC, S_DONE
   } state_t;

   localparam logic [3:0]       CMD_NOP = 4'b1111;
   localparam logic [3:0]       CMD_PRE = 4'b0010;
   localparam logic [3:0]       CMD_ACT = 4'b0011;
   localparam logic [3:0]       CMD_WR  = 4'b0100;
   localparam logic [3:0]       CMD_RD  = 4'b0101;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cmd_d;
   logic [31:0]      addr_d;
   logic [1:0]       size_d;
   logic             done_d, busy_d, ready_d;

   // request fields captured at accept
   logic             we_q;
   logic [7:0]       row_q, col_q;
   logic [1:0]       size_q;
   logic [CNT_W-1:0] tpre_q, tcas_q, tburst_q, twait_q;
   logic [3:0]       tlat_q;

   logic             accept, row_hit;
   logic [3:0]       lat_m1;
   logic [CNT_W-1:0] burst_m1, rw_load;
   logic [CNT_W:0]   rw_sum;
   logic             unused_addr_hi;

   assign unused_addr_hi = ^ReqAddr[31:16];
   assign accept         = (state_q == S_IDLE) && ReqValid && ReqReady;

   // Each term of the post-command count saturates at 0; the widened sum saturates at all-ones.
   assign lat_m1   = (!we_q && tlat_q != 4'd0) ? tlat_q - 4'd1 : 4'd0;
   assign burst_m1 = (tburst_q != '0) ? tburst_q - ONE : '0;
   assign rw_sum   = {{(CNT_W-3){1'b0}}, lat_m1} + {1'b0, burst_m1};
   assign rw_load  = rw_sum[CNT_W] ? '1 : rw_sum[CNT_W-1:0];

`ifdef OPEN_ROW_EN
   logic [7:0] open_row_q;
   logic       open_valid_q;

   assign row_hit = open_valid_q && (ReqAddr[15:8] == open_row_q);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         open_row_q   <= 8'h00;
         open_valid_q <= 1'b0;
      end else if (state_q == S_ACT) begin
         open_row_q   <= row_q;
         open_valid_q <= 1'b1;
      end
   end
`else
   assign row_hit = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      cmd_d   = CMD_NOP;
      addr_d  = AddrOut;
      size_d  = SizeOut;
      done_d  = 1'b0;
      busy_d  = (state_q != S_IDLE);
      ready_d = (state_q == S_IDLE) && !accept;
      unique case (state_q)
         S_IDLE:  if (accept) state_d = row_hit ? S_RW : S_PRE;
         S_PRE: begin
            cmd_d   = CMD_PRE;
            cnt_d   = tpre_q;
            state_d = (tpre_q == '0) ? S_ACT : S_PRE_W;
         end
         S_PRE_W: if (cnt_q > ONE) cnt_d = cnt_q - ONE; else state_d = S_ACT;
         S_ACT: begin
            cmd_d   = CMD_ACT;
            addr_d  = {24'h0, row_q};
            cnt_d   = tcas_q;
            state_d = (tcas_q == '0) ? S_RW : S_ACT_W;
         end
         S_ACT_W: if (cnt_q > ONE) cnt_d = cnt_q - ONE; else state_d = S_RW;
         S_RW: begin
            cmd_d  = we_q ? CMD_WR : CMD_RD;
            addr_d = {24'h0, col_q};
            size_d = size_q;
            if (rw_load != '0) begin
               cnt_d   = rw_load;
               state_d = S_DATA;
            end else if (twait_q != '0) begin
               cnt_d   = twait_q;
               state_d = S_REC;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DATA: begin
            if (cnt_q > ONE) begin
               cnt_d = cnt_q - ONE;
            end else if (twait_q != '0) begin
               cnt_d   = twait_q;
               state_d = S_REC;
            end else begin
               state_d = S_DONE;
            end
         end
         S_REC:   if (cnt_q > ONE) cnt_d = cnt_q - ONE; else state_d = S_DONE;
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q                <= S_IDLE;
         cnt_q                  <= '0;
         {CS, RAS, CAS, WeOut}  <= CMD_NOP;
         AddrOut                <= 32'h0;
         SizeOut                <= 2'b00;
         Busy                   <= 1'b0;
         Done                   <= 1'b0;
         ReqReady               <= 1'b1;
         we_q                   <= 1'b0;
         row_q                  <= 8'h00;
         col_q                  <= 8'h00;
         size_q                 <= 2'b00;
         tpre_q                 <= '0;
         tcas_q                 <= '0;
         tlat_q                 <= 4'd0;
         tburst_q               <= '0;
         twait_q                <= '0;
      end else begin
         state_q                <= state_d;
         cnt_q                  <= cnt_d;
         {CS, RAS, CAS, WeOut}  <= cmd_d;
         AddrOut                <= addr_d;
         SizeOut                <= size_d;
         Busy                   <= busy_d;
         Done                   <= done_d;
         ReqReady               <= ready_d;
         if (accept) begin
            we_q     <= ReqWe;
            row_q    <= ReqAddr[15:8];
            col_q    <= ReqAddr[7:0];
            size_q   <= ReqSize;
            tpre_q   <= tpre;
            tcas_q   <= tcas;
            tlat_q   <= tlat;
            tburst_q <= tburst;
            twait_q  <= twait;
         end
      end
   end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Scoreboard bench for sdram_cmd_sequencer: expected command/Done events are queued at accept
// and compared (value and cycle) as the DUT emits them.
module tb_sdram_cmd_sequencer;

   localparam logic [3:0] NOP = 4'b1111;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] RD  = 4'b0101;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [7:0]  tpre, tcas, tburst, twait;
   logic [3:0]  tlat;
   logic        cs, ras, cas, we_out;
   logic [31:0] addr_out;
   logic [1:0]  size_out;
   logic        busy, done;
   logic [3:0]  cmd_bus;

   assign cmd_bus = {cs, ras, cas, we_out};

   sdram_cmd_sequencer #(.CNT_W(8)) dut (
      .Clk(clk), .Rst(rst),
      .ReqValid(req_valid), .ReqReady(req_ready), .ReqWe(req_we),
      .ReqAddr(req_addr), .ReqSize(req_size),
      .tpre(tpre), .tcas(tcas), .tlat(tlat), .tburst(tburst), .twait(twait),
      .CS(cs), .RAS(ras), .CAS(cas), .WeOut(we_out),
      .AddrOut(addr_out), .SizeOut(size_out), .Busy(busy), .Done(done)
   );

   typedef struct {
      logic [3:0]  cmd;
      logic        done;
      logic [31:0] addr;
      logic [1:0]  size;
      bit          chk_addr;
      bit          chk_size;
      int          t;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          last_acc;
   bit          model_open_valid = 1'b0;
   logic [7:0]  model_open_row   = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input logic [3:0] c, input logic d, input logic [31:0] a,
                          input logic [1:0] s, input bit ca, input bit cz, input int t);
      exp_t e;
      e.cmd = c; e.done = d; e.addr = a; e.size = s;
      e.chk_addr = ca; e.chk_size = cz; e.t = t;
      exp_q.push_back(e);
   endtask

   // Monitor: every non-NOP command or Done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (cmd_bus != NOP || done)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({cmd_bus, done}), 32'({NOP, 1'b0}));
         end else begin
            mon_e = exp_q.pop_front();
            check("event", 32'({cmd_bus, done}), 32'({mon_e.cmd, mon_e.done}));
            check("event_cycle", 32'(cyc), 32'(mon_e.t));
            if (mon_e.chk_addr) check("addr_out", addr_out, mon_e.addr);
            if (mon_e.chk_size) check("size_out", 32'(size_out), 32'(mon_e.size));
            if (!mon_e.done) begin
               check("busy_in_seq", 32'(busy), 32'd1);
               check("ready_in_seq", 32'(req_ready), 32'd0);
            end
         end
      end
   end

   // Presents one request, waits for the handshake, then queues the expected events.
   task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input int tp, input int tc, input int tl, input int tb, input int tw,
                       input bit abort);
      bit hit;
      int acc, t_rw, d, n;
      @(negedge clk);
      req_we = we; req_addr = addr; req_size = size;
      tpre = 8'(tp); tcas = 8'(tc); tlat = 4'(tl); tburst = 8'(tb); twait = 8'(tw);
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
      acc = cyc + 1;
      hit = 1'b0;
`ifdef OPEN_ROW_EN
      hit = model_open_valid && (addr[15:8] == model_open_row);
`endif
      if (hit) begin
         t_rw = acc + 1;
      end else begin
         push_ev(PRE, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, acc + 1);
         push_ev(ACT, 1'b0, {24'h0, addr[15:8]}, 2'b00, 1'b1, 1'b0, acc + 1 + tp + 1);
         t_rw = acc + 1 + tp + 1 + tc + 1;
         model_open_row   = addr[15:8];
         model_open_valid = 1'b1;
      end
      if (!abort) begin
         d = (we ? 0 : (tl > 0 ? tl - 1 : 0)) + (tb > 0 ? tb - 1 : 0);
         if (d > 255) d = 255;
         push_ev(we ? WR : RD, 1'b0, {24'h0, addr[7:0]}, size, 1'b1, 1'b1, t_rw);
         push_ev(NOP, 1'b1, 32'h0, 2'b00, 1'b0, 1'b0, t_rw + d + tw + 1);
      end
      last_acc = acc;
      @(posedge clk);
      #1;
      // Scramble inputs so any use of live (unlatched) values shows up as a mismatch.
      req_valid = 1'b0;
      req_we = ~we; req_addr = $urandom; req_size = 2'($urandom_range(0, 3));
      tpre = 8'($urandom_range(0, 255)); tcas = 8'($urandom_range(0, 255));
      tlat = 4'($urandom_range(0, 15)); tburst = 8'($urandom_range(0, 255));
      twait = 8'($urandom_range(0, 255));
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ready_back", 32'(req_ready), 32'd1);
      check("busy_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'b00;
      tpre = 8'd0; tcas = 8'd0; tlat = 4'd0; tburst = 8'd0; twait = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cmd",   32'(cmd_bus),   32'(NOP));
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_done",  32'(done),      32'd0);
      check("rst_addr",  addr_out,       32'h0);
      check("rst_size",  32'(size_out),  32'd0);
      rst = 1'b0;

      // Write, then a read held on ReqValid while the write is still busy.
      send(1'b1, 32'h0000_AABB, 2'b10, 3, 5, 0, 8, 3, 1'b0);
      send(1'b0, 32'h0000_125A, 2'b01, 3, 5, 7, 8, 3, 1'b0);
      drain(400);

      // All-zero spacing: PRE, ACT, WR back to back, Done right after WR.
      send(1'b1, 32'h0000_0F0E, 2'b00, 0, 0, 0, 1, 0, 1'b0);
      drain(100);

      // Saturating count load and zero-length write burst.
      send(1'b0, 32'h0000_7733, 2'b10, 1, 2, 15, 255, 0, 1'b0);
      drain(600);
      send(1'b1, 32'h0000_7744, 2'b01, 2, 1, 9, 0, 2, 1'b0);
      drain(100);

      // Reset two cycles after ACT aborts the sequence with no Done.
      send(1'b0, 32'h0000_5621, 2'b10, 3, 5, 4, 8, 3, 1'b1);
      while (cyc < last_acc + 6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_cmd",   32'(cmd_bus),   32'(NOP));
      check("abort_busy",  32'(busy),      32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_done",  32'(done),      32'd0);
      rst = 1'b0;
      model_open_valid = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_no_pending", 32'(exp_q.size()), 32'd0);
      send(1'b1, 32'h0000_5621, 2'b00, 2, 3, 0, 4, 1, 1'b0);
      drain(200);

      // Two reads to row 0x12 then one to row 0x34 (row hit only with open-row tracking).
      send(1'b0, 32'h0000_1201, 2'b10, 2, 2, 3, 2, 1, 1'b0);
      drain(200);
      send(1'b0, 32'h0000_1202, 2'b01, 2, 2, 3, 2, 1, 1'b0);
      drain(200);
      send(1'b0, 32'h0000_3403, 2'b00, 2, 2, 3, 2, 1, 1'b0);
      drain(200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
